data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//   Responder end of the MEM-stage data-memory interface: a word-addressed data memory with
//   a valid/ready request port and a fixed, programmable access latency. Accepts one
//   load/store at a time from the pipeline's MEM stage and asserts mem_stall while busy.
//   Returns read data with a one-cycle resp_valid pulse.
// PARAMETERS
//   DATA_W   32   data word width
//   ADDR_W   32   request address width (word address; consecutive words differ by 1)
//   DEPTH    256  number of words stored; valid addresses 0..DEPTH-1
//   LATENCY  2    cycles from accept to response, legal range 1..15
// PORTS
//   clk         in   1       clock, rising edge
//   rst         in   1       asynchronous reset, active-high
//   req_valid   in   1       MEM stage presents a request
//   req_we      in   1       1 = store, 0 = load
//   req_addr    in   ADDR_W  word address
//   req_wdata   in   DATA_W  store data
//   req_ready   out  1       responder can accept (IDLE only)
//   resp_valid  out  1       one-cycle pulse: access complete
//   resp_rdata  out  DATA_W  load data; 0 for stores and errors
//   resp_err    out  1       valid with resp_valid: address >= DEPTH
//   mem_stall   out  1       hold pipeline (PC, IF/ID, ID/EX, EX/MEM)
// BEHAVIOUR
// - Reset (async, any state): state=IDLE, cnt=0, resp_valid=0, resp_rdata=0, resp_err=0.
//   All DEPTH words cleared to 0. An in-flight request is dropped; a pending store is not written.
// - FSM IDLE / WAIT / RESP:
//   IDLE: req_ready=1.
//     - Accept when req_valid=1: register we/addr/wdata, set cnt=LATENCY-1.
//     - Next state: WAIT if LATENCY>1, else RESP.
//   WAIT: req_ready=0. cnt decrements each cycle; at cnt==1 the next state is RESP.
//     Request inputs are ignored (registered copy used).
//   RESP: req_ready=0, resp_valid=1 for exactly this cycle; next state IDLE unconditionally.
// - Access point: performed on the clock edge entering RESP.
//   - Store: mem[addr] <= wdata; resp_rdata=0.
//   - Load: resp_rdata <= mem[addr] (value after any earlier completed store).
// - resp_rdata/resp_err are registered and hold their values until the next RESP or reset.
// - Out-of-range address (addr >= DEPTH, full ADDR_W compare, no wrap):
//   resp_err=1, resp_rdata=0, no write. Latency is unchanged.
// - mem_stall = (state==IDLE & req_valid) | (state==WAIT). Deasserted in RESP, so the
//   pipeline advances on the RESP edge and captures resp_rdata.
// - Back-to-back requests: RESP is always followed by IDLE. A req_valid still high during RESP
//   is not accepted. Sustained throughput is 1 request per LATENCY+1 cycles.
// - Latency: resp_valid is high exactly LATENCY cycles after the accept cycle.
// - Counter is 4 bits wide. LATENCY=1 skips WAIT entirely.
// TESTING
// - Reset then load addr 5:
//   - resp_valid 2 cycles after accept, resp_rdata=0, resp_err=0.
//   - mem_stall high for exactly 2 cycles.
// - Store 0xDEADBEEF to addr 10, then load addr 10:
//   - load returns 0xDEADBEEF.
//   - Store response has rdata=0.
//   - Second accept occurs 1 cycle after the first RESP.
// - Load addr 256 (DEPTH=256):
//   - resp_err=1, rdata=0.
//   - Then a store to addr 256 followed by a load of addr 0 returns 0 (no aliasing).
// - Assert rst during WAIT of a store to addr 3 with data 0x1234:
//   - All outputs go to reset values immediately, with no resp_valid.
//   - A later load of addr 3 returns 0.
// - LATENCY=1 and LATENCY=15 builds, held req_valid:
//   - resp_valid spacing is 2 and 16 cycles respectively.
//   - resp_valid is never high for two consecutive cycles.

Source files
------------

// File: rtl/data_mem_responder.sv
// Word-addressed data memory answering MEM-stage loads and stores after a fixed LATENCY.
// One request is in flight at a time; mem_stall holds the pipeline until the response cycle.
module data_mem_responder #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              req_ready,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic              mem_stall
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t            state, state_nxt;
   logic [3:0]        cnt, cnt_nxt;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              accept;
   logic              access;
   logic              acc_we;
   logic              acc_err;
   logic [ADDR_W-1:0] acc_addr;
   logic [DATA_W-1:0] acc_wdata;
   logic [IDX_W-1:0]  acc_idx;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      req_ready = 1'b0;
      accept    = 1'b0;
      access    = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               accept  = 1'b1;
               cnt_nxt = 4'(LATENCY - 1);
               if (LATENCY > 1) begin
                  state_nxt = WAIT;
               end else begin
                  state_nxt = RESP;
                  access    = 1'b1;
               end
            end
         end
         WAIT: begin
            cnt_nxt = cnt - 4'd1;
            if (cnt == 4'd1) begin
               state_nxt = RESP;
               access    = 1'b1;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // With LATENCY=1 the access happens on the accept edge, before the request copy exists.
   assign acc_we    = (state == IDLE) ? req_we    : we_q;
   assign acc_addr  = (state == IDLE) ? req_addr  : addr_q;
   assign acc_wdata = (state == IDLE) ? req_wdata : wdata_q;
   assign acc_err   = (acc_addr >= ADDR_W'(DEPTH));
   assign acc_idx   = acc_addr[IDX_W-1:0];

   assign resp_valid = (state == RESP);
   assign mem_stall  = ((state == IDLE) && req_valid) || (state == WAIT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
         end
         if (access) begin
            resp_err   <= acc_err;
            resp_rdata <= (acc_we || acc_err) ? '0 : mem[acc_idx];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (access && acc_we && !acc_err) begin
         mem[acc_idx] <= acc_wdata;
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized scoreboard bench for data_mem_responder, plus LATENCY=1/15 throughput instances.
module tb_data_mem_responder;

   localparam int DW    = 32;
   localparam int AW    = 32;
   localparam int DEPTH = 256;
   localparam int LAT   = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid, req_we;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          req_ready, resp_valid, resp_err, mem_stall;
   logic [DW-1:0] resp_rdata;

   logic          h_valid;
   logic          h_we    = 1'b0;
   logic [AW-1:0] h_addr  = '0;
   logic [DW-1:0] h_wdata = '0;
   logic          r1_ready, r1_valid, r1_err, r1_stall;
   logic [DW-1:0] r1_rdata;
   logic          r15_ready, r15_valid, r15_err, r15_stall;
   logic [DW-1:0] r15_rdata;

   always #5 clk = ~clk;

   data_mem_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_ready(req_ready), .resp_valid(resp_valid),
      .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_stall(mem_stall));

   data_mem_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .LATENCY(1)) u_lat1 (
      .clk(clk), .rst(rst), .req_valid(h_valid), .req_we(h_we), .req_addr(h_addr),
      .req_wdata(h_wdata), .req_ready(r1_ready), .resp_valid(r1_valid),
      .resp_rdata(r1_rdata), .resp_err(r1_err), .mem_stall(r1_stall));

   data_mem_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .LATENCY(15)) u_lat15 (
      .clk(clk), .rst(rst), .req_valid(h_valid), .req_we(h_we), .req_addr(h_addr),
      .req_wdata(h_wdata), .req_ready(r15_ready), .resp_valid(r15_valid),
      .resp_rdata(r15_rdata), .resp_err(r15_err), .mem_stall(r15_stall));

   typedef struct {
      logic [DW-1:0] rdata;
      logic          err;
      int            acc;
   } exp_t;

   exp_t          sb[$];
   logic [DW-1:0] model [DEPTH];
   int            cyc = 0;
   int            checks = 0;
   int            passes = 0;
   int            stall_cnt = 0;
   int            last_resp = -1;
   int            prev_resp = -1;
   exp_t          mon_e;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      sb.delete();
   endtask

   // Called at a negedge; holds req_valid until the request is taken, then drops it.
   task automatic do_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
      int   t = 0;
      exp_t e;
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
      #1;
      while (!req_ready && t < 100) begin
         @(negedge clk); #1; t++;
      end
      if (t >= 100) begin
         chk("accept_timeout", 0, 1);
         req_valid = 1'b0;
         return;
      end
      e.acc   = cyc;
      e.err   = (addr >= AW'(DEPTH));
      e.rdata = '0;
      if (!e.err) begin
         if (we) model[addr[7:0]] = wd;
         else    e.rdata = model[addr[7:0]];
      end
      sb.push_back(e);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while (sb.size() > 0 && t < 60) begin
         @(negedge clk); t++;
      end
      if (sb.size() > 0) chk("drain_timeout", sb.size(), 0);
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      #2;
      if (rst) begin
         stall_cnt = 0;
      end else begin
         if (mem_stall) stall_cnt++;
         if (resp_valid) begin
            prev_resp = last_resp;
            last_resp = cyc;
            if (sb.size() == 0) begin
               chk("unexpected_resp", 1, 0);
            end else begin
               mon_e = sb.pop_front();
               chk("resp_rdata", resp_rdata, mon_e.rdata);
               chk("resp_err", resp_err, mon_e.err);
               chk("latency", cyc - mon_e.acc, LAT);
               chk("stall_cycles", stall_cnt, LAT);
            end
            stall_cnt = 0;
         end
      end
   end

   initial begin
      int last1, last15;
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      h_valid = 1'b0;
      model_reset();
      #1;
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_rdata", resp_rdata, 0);
      chk("rst_resp_err", resp_err, 0);
      chk("rst_req_ready", req_ready, 1);
      chk("rst_mem_stall", mem_stall, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      do_req(1'b0, 32'd5, '0);
      drain();

      do_req(1'b1, 32'd10, 32'hDEADBEEF);
      do_req(1'b0, 32'd10, '0);
      drain();
      chk("b2b_spacing", last_resp - prev_resp, LAT + 1);

      do_req(1'b0, 32'd256, '0);
      do_req(1'b1, 32'd256, 32'h5555AAAA);
      do_req(1'b0, 32'd0, '0);
      do_req(1'b1, 32'hFFFF_FF00, 32'h77);
      do_req(1'b0, 32'd255, '0);
      drain();

      for (int n = 0; n < 60; n++) begin
         logic [AW-1:0] a;
         case ($urandom_range(0, 7))
            0:       a = $urandom;
            1:       a = AW'($urandom_range(250, 262));
            default: a = AW'($urandom_range(0, 19));
         endcase
         do_req(1'($urandom_range(0, 1)), a, $urandom);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      drain();

      do_req(1'b1, 32'd7, 32'hA5A5A5A5);
      do_req(1'b0, 32'd7, '0);
      drain();

      // Store to addr 3, then reset mid-WAIT: the store must be dropped.
      do_req(1'b1, 32'd3, 32'h1234);
      rst = 1'b1;
      #1;
      chk("midrst_resp_valid", resp_valid, 0);
      chk("midrst_resp_rdata", resp_rdata, 0);
      chk("midrst_resp_err", resp_err, 0);
      chk("midrst_req_ready", req_ready, 1);
      chk("midrst_mem_stall", mem_stall, 0);
      model_reset();
      repeat (3) begin
         @(negedge clk); #1;
         chk("rst_no_resp", resp_valid, 0);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      do_req(1'b0, 32'd3, '0);
      do_req(1'b0, 32'd7, '0);
      do_req(1'b0, 32'd10, '0);
      drain();

      // Held req_valid on the LATENCY=1 and LATENCY=15 instances.
      last1 = -1; last15 = -1;
      h_valid = 1'b1;
      for (int n = 0; n < 80; n++) begin
         @(negedge clk); #1;
         if (r1_valid) begin
            if (last1 >= 0) chk("lat1_spacing", cyc - last1, 2);
            last1 = cyc;
         end
         if (r15_valid) begin
            if (last15 >= 0) chk("lat15_spacing", cyc - last15, 16);
            last15 = cyc;
         end
      end
      h_valid = 1'b0;
      chk("lat1_seen", (last1 >= 0) ? 1 : 0, 1);
      chk("lat15_seen", (last15 >= 0) ? 1 : 0, 1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
